bin2bcd_dd_seq: RTL and testbench

//  Parametrised sequential double-dabble converter: binary word in, packed BCD

---
 rtl/bin2bcd_dd_seq.sv | 124 ++++++++++++
 tb/tb_bin2bcd_dd_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_dd_seq.sv
// Sequential double-dabble converter: binary operand in, packed BCD digits out,
// with overflow and leading-zero flags held stable between conversions.
module bin2bcd_dd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic [BCD_W-1:0]   acc, acc_next, acc_added, acc_shifted;
    logic [BIN_W-1:0]   sr, sr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               ovf_work, ovf_work_next;
    logic [BCD_W-1:0]   bcd_next;
    logic               ovf_next;
    logic [DIGITS-1:0]  lz_next, lz_shifted;
    logic               all_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            acc      <= '0;
            sr       <= '0;
            cnt      <= '0;
            ovf_work <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            lz_mask  <= '0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            sr       <= sr_next;
            cnt      <= cnt_next;
            ovf_work <= ovf_work_next;
            bcd      <= bcd_next;
            ovf      <= ovf_next;
            lz_mask  <= lz_next;
        end
    end

    // Digits are adjusted independently; no carry crosses a digit boundary.
    always_comb begin
        acc_added = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_added[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acc_shifted = {acc[BCD_W-2:0], sr[BIN_W-1]};

    // A digit is blank when it and every digit above it are zero; units never blank.
    always_comb begin
        lz_shifted = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (acc_shifted[4*i +: 4] != 4'd0) begin
                all_zero = 1'b0;
            end
            lz_shifted[i] = all_zero;
        end
    end

    always_comb begin
        state_next    = state;
        acc_next      = acc;
        sr_next       = sr;
        cnt_next      = cnt;
        ovf_work_next = ovf_work;
        bcd_next      = bcd;
        ovf_next      = ovf;
        lz_next       = lz_mask;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    acc_next      = '0;
                    sr_next       = bin;
                    cnt_next      = '0;
                    ovf_work_next = 1'b0;
                    state_next    = ADD;
                end else begin
                    state_next = IDLE;
                end
            end
            ADD: begin
                acc_next   = acc_added;
                state_next = SHIFT;
            end
            SHIFT: begin
                {acc_next, sr_next} = {acc[BCD_W-2:0], sr, 1'b0};
                ovf_work_next       = ovf_work | acc[BCD_W-1];
                cnt_next            = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    state_next = DONE;
                    bcd_next   = acc_shifted;
                    ovf_next   = ovf_work | acc[BCD_W-1];
                    lz_next    = lz_shifted;
                end else begin
                    state_next = ADD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == ADD) || (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_dd_seq.sv
// Scoreboard bench for bin2bcd_dd_seq: a 12-bit and a 14-bit instance driven
// with directed and random operands, checked against a decimal-arithmetic model.
module tb_bin2bcd_dd_seq;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  lz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start12, start14;
    logic [11:0] bin12;
    logic [13:0] bin14;
    logic        busy12, done12, ovf12, busy14, done14, ovf14;
    logic [15:0] bcd12, bcd14;
    logic [3:0]  lz12, lz14;

    int          tests = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    exp_t        q12[$];
    exp_t        q14[$];
    exp_t        hold12, hold14;

    bin2bcd_dd_seq #(.BIN_W(12), .DIGITS(4)) dut12 (
        .clk(clk), .reset_n(reset_n), .start(start12), .bin(bin12),
        .busy(busy12), .done(done12), .bcd(bcd12), .ovf(ovf12), .lz_mask(lz12)
    );

    bin2bcd_dd_seq #(.BIN_W(14), .DIGITS(4)) dut14 (
        .clk(clk), .reset_n(reset_n), .start(start14), .bin(bin14),
        .busy(busy14), .done(done14), .bcd(bcd14), .ovf(ovf14), .lz_mask(lz14)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference: low four digits of the value, overflow past 9999, and a
    // digit counts as leading zero when the kept value is below its place weight.
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned m, t, p;
        m     = v % 10000;
        t     = m;
        e.ovf = (v > 9999);
        e.bcd = '0;
        e.lz  = '0;
        for (int i = 0; i < 4; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        p = 10;
        for (int i = 1; i < 4; i++) begin
            if (m < p) e.lz[i] = 1'b1;
            p = p * 10;
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : mon12
        exp_t e;
        if (!reset_n) begin
            q12.delete();
            hold12 = '0;
        end else if (done12) begin
            if (q12.size() == 0) begin
                check_output("unexpected_done12", 32'(done12), 32'd0);
            end else begin
                e = q12.pop_front();
                check_output("bcd12", 32'(bcd12), 32'(e.bcd));
                check_output("ovf12", 32'(ovf12), 32'(e.ovf));
                check_output("lz12", 32'(lz12), 32'(e.lz));
                hold12 = e;
            end
        end else begin
            check_output("hold12", 32'({bcd12, ovf12, lz12}), 32'(hold12));
        end
    end

    always @(negedge clk) begin : mon14
        exp_t e;
        if (!reset_n) begin
            q14.delete();
            hold14 = '0;
        end else if (done14) begin
            if (q14.size() == 0) begin
                check_output("unexpected_done14", 32'(done14), 32'd0);
            end else begin
                e = q14.pop_front();
                check_output("bcd14", 32'(bcd14), 32'(e.bcd));
                check_output("ovf14", 32'(ovf14), 32'(e.ovf));
                check_output("lz14", 32'(lz14), 32'(e.lz));
                hold14 = e;
            end
        end else begin
            check_output("hold14", 32'({bcd14, ovf14, lz14}), 32'(hold14));
        end
    end

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy12"}, 32'(busy12), 32'd0);
        check_output({tag, "_done12"}, 32'(done12), 32'd0);
        check_output({tag, "_out12"}, 32'({bcd12, ovf12, lz12}), 32'd0);
        check_output({tag, "_busy14"}, 32'(busy14), 32'd0);
        check_output({tag, "_done14"}, 32'(done14), 32'd0);
        check_output({tag, "_out14"}, 32'({bcd14, ovf14, lz14}), 32'd0);
    endtask

    task automatic wait_idle12();
        int n = 0;
        while (busy12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("idle12_timeout", 32'(busy12), 32'd0);
    endtask

    // One conversion on the 12-bit unit, timing measured from the cycle start is presented.
    task automatic apply_stimulus12(input int unsigned v);
        int cyc_n, busy_n;
        wait_idle12();
        start12 = 1'b1;
        bin12   = 12'(v);
        q12.push_back(model(v));
        @(negedge clk);
        start12 = 1'b0;
        cyc_n   = 1;
        busy_n  = 0;
        while (!done12 && cyc_n < 200) begin
            if (busy12) busy_n++;
            @(negedge clk);
            cyc_n++;
        end
        check_output("done12_seen", 32'(done12), 32'd1);
        check_output("latency12", 32'(cyc_n), 32'd25);
        check_output("busy_cycles12", 32'(busy_n), 32'd24);
        @(negedge clk);
    endtask

    task automatic apply_stimulus14(input int unsigned v);
        int cyc_n, n;
        n = 0;
        while (busy14 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("idle14_timeout", 32'(busy14), 32'd0);
        start14 = 1'b1;
        bin14   = 14'(v);
        q14.push_back(model(v));
        @(negedge clk);
        start14 = 1'b0;
        cyc_n   = 1;
        while (!done14 && cyc_n < 200) begin
            @(negedge clk);
            cyc_n++;
        end
        check_output("done14_seen", 32'(done14), 32'd1);
        check_output("latency14", 32'(cyc_n), 32'd29);
        @(negedge clk);
    endtask

    // start held high: each acceptance happens on the DONE cycle of the previous run.
    task automatic back_to_back12(input int count, input bit random_mode);
        int unsigned v, last;
        int n;
        last    = 0;
        start12 = 1'b1;
        for (int k = 0; k < count; k++) begin
            v     = random_mode ? $urandom_range(0, 4095) : k;
            bin12 = 12'(v);
            n     = 0;
            while (busy12 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check_output("b2b_timeout", 32'(busy12), 32'd0);
            q12.push_back(model(v));
            if (k > 0) check_output("b2b_period", cyc - last, 32'd25);
            last = cyc;
            @(negedge clk);
        end
        start12 = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q12.size() != 0 || q14.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("drain", 32'(q12.size() + q14.size()), 32'd0);
    endtask

    initial begin
        int n;
        int unsigned edge_vals[8] = '{0, 9, 10, 99, 100, 999, 1000, 4095};

        reset_n = 1'b0;
        start12 = 1'b0;
        start14 = 1'b0;
        bin12   = '0;
        bin14   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        apply_stimulus12(0);
        apply_stimulus12(4095);

        // A start pulse mid-conversion must be ignored and leave the result alone.
        wait_idle12();
        start12 = 1'b1;
        bin12   = 12'd100;
        q12.push_back(model(100));
        @(negedge clk);
        start12 = 1'b0;
        repeat (4) @(negedge clk);
        start12 = 1'b1;
        bin12   = 12'd7;
        @(negedge clk);
        start12 = 1'b0;
        n = 0;
        while (!done12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("ignored_start_done", 32'(done12), 32'd1);
        check_output("ignored_start_bcd", 32'(bcd12), 32'h0100);
        repeat (40) @(negedge clk);

        // Reset mid-conversion abandons the run without a done pulse.
        wait_idle12();
        start12 = 1'b1;
        bin12   = 12'd123;
        q12.push_back(model(123));
        @(negedge clk);
        start12 = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        check_all_zero("abort_hold");
        reset_n = 1'b1;
        @(negedge clk);
        apply_stimulus12(77);
        check_output("after_reset_bcd", 32'(bcd12), 32'h0077);

        back_to_back12(21, 1'b0);
        wait_drain();

        foreach (edge_vals[i]) apply_stimulus12(edge_vals[i]);

        back_to_back12(800, 1'b1);
        wait_drain();

        apply_stimulus14(16383);
        check_output("w14_max_bcd", 32'(bcd14), 32'h6383);
        check_output("w14_max_ovf", 32'(ovf14), 32'd1);
        apply_stimulus14(9999);
        apply_stimulus14(10000);
        apply_stimulus14(10042);
        for (int k = 0; k < 60; k++) apply_stimulus14($urandom_range(0, 16383));
        wait_drain();

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
